// File: rtl/wb_arbiter_pkg.sv
// Shared Wishbone defaults and a small wrap-around helper for the arbiter slice.
package wb_arbiter_pkg;

    localparam int unsigned WbMasterCount = 2;
    localparam int unsigned WbDataWidth   = 32;
    localparam int unsigned WbAddrWidth   = 32;

    // Folds idx back into [0, count) for idx < 2*count; avoids a generic modulo.
    function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned count);
        return (idx >= count) ? idx - count : idx;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle for the N-master to 1-slave Wishbone B4 pipelined arbiter.
interface wb_arbiter_if
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned Count     = WbMasterCount,
    parameter int unsigned DataWidth = WbDataWidth,
    parameter int unsigned AddrWidth = WbAddrWidth
);
    localparam int unsigned SelWidth = DataWidth / 8;

    // Master side, one lane per initiator
    logic [Count-1:0][DataWidth-1:0] m_data_m;
    logic [Count-1:0][AddrWidth-1:0] m_addr;
    logic [Count-1:0][SelWidth-1:0]  m_sel;
    logic [Count-1:0]                m_cyc;
    logic [Count-1:0]                m_stb;
    logic [Count-1:0]                m_we;
    logic [Count-1:0][DataWidth-1:0] m_data_s;
    logic [Count-1:0]                m_ack;
    logic [Count-1:0]                m_err;
    logic [Count-1:0]                m_stall;

    // Shared slave port
    logic [DataWidth-1:0] s_data_m;
    logic [AddrWidth-1:0] s_addr;
    logic [SelWidth-1:0]  s_sel;
    logic                 s_cyc;
    logic                 s_stb;
    logic                 s_we;
    logic [DataWidth-1:0] s_data_s;
    logic                 s_ack;
    logic                 s_err;
    logic                 s_stall;

    // Seen from the initiators
    modport master (
        output m_data_m, m_addr, m_sel, m_cyc, m_stb, m_we,
        input  m_data_s, m_ack, m_err, m_stall
    );

    // Seen from the shared slave device
    modport slave (
        input  s_data_m, s_addr, s_sel, s_cyc, s_stb, s_we,
        output s_data_s, s_ack, s_err, s_stall
    );

    // Seen from the arbiter sitting between the two
    modport arbiter (
        input  m_data_m, m_addr, m_sel, m_cyc, m_stb, m_we,
        output m_data_s, m_ack, m_err, m_stall,
        output s_data_m, s_addr, s_sel, s_cyc, s_stb, s_we,
        input  s_data_s, s_ack, s_err, s_stall
    );

endinterface

// File: rtl/wb_rr_picker.sv
// Combinational round-robin selector: first requester after last_idx, wrapping.
module wb_rr_picker
    import wb_arbiter_pkg::*;
#(
    parameter  int unsigned Count    = WbMasterCount,
    localparam int unsigned IdxWidth = $clog2(Count)
) (
    input  logic [Count-1:0]    req,
    input  logic [IdxWidth-1:0] last_idx,
    output logic                any,
    output logic [IdxWidth-1:0] idx
);

    logic [IdxWidth-1:0] cand;

    // Scan farthest-first so the nearest requester after last_idx is written last and wins
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int unsigned k = Count; k >= 1; k--) begin
            cand = IdxWidth'(rr_wrap(32'(last_idx) + k, Count));
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// N-master to 1-slave Wishbone B4 pipelined arbiter; grant held per whole m_cyc, round-robin.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned Count     = WbMasterCount,
    parameter int unsigned DataWidth = WbDataWidth,
    parameter int unsigned AddrWidth = WbAddrWidth
) (
    input logic           clk,
    input logic           reset_n,
    wb_arbiter_if.arbiter bus
);

    localparam int unsigned IdxWidth = $clog2(Count);

    logic                gnt_valid_q, gnt_valid_d;
    logic [IdxWidth-1:0] gnt_idx_q, gnt_idx_d;
    logic [IdxWidth-1:0] last_idx_q, last_idx_d;
    logic                pick_any;
    logic [IdxWidth-1:0] pick_idx;

    wb_rr_picker #(
        .Count(Count)
    ) u_picker (
        .req     (bus.m_cyc),
        .last_idx(last_idx_q),
        .any     (pick_any),
        .idx     (pick_idx)
    );

    // Grant state register; last_idx resets to Count-1 so master 0 has first priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            last_idx_q  <= IdxWidth'(Count - 1);
        end else begin
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            last_idx_q  <= last_idx_d;
        end
    end

    // Next grant: arbitrate only from idle, release when the owner drops cyc
    always_comb begin
        gnt_valid_d = gnt_valid_q;
        gnt_idx_d   = gnt_idx_q;
        last_idx_d  = last_idx_q;
        if (!gnt_valid_q) begin
            if (pick_any) begin
                gnt_valid_d = 1'b1;
                gnt_idx_d   = pick_idx;
                last_idx_d  = pick_idx;
            end
        end else if (!bus.m_cyc[gnt_idx_q]) begin
            // Forces one idle cycle between owners
            gnt_valid_d = 1'b0;
        end
    end

    // Steering: owner's request to the slave, slave's response back to the owner only
    always_comb begin
        bus.s_addr   = bus.m_addr[gnt_idx_q];
        bus.s_data_m = bus.m_data_m[gnt_idx_q];
        bus.s_sel    = bus.m_sel[gnt_idx_q];
        bus.s_we     = bus.m_we[gnt_idx_q];
        bus.s_cyc    = gnt_valid_q & bus.m_cyc[gnt_idx_q];
        bus.s_stb    = gnt_valid_q & bus.m_stb[gnt_idx_q];
        bus.m_ack    = '0;
        bus.m_err    = '0;
        bus.m_stall  = '1;
        if (gnt_valid_q) begin
            bus.m_ack[gnt_idx_q]   = bus.s_ack;
            bus.m_err[gnt_idx_q]   = bus.s_err;
            bus.m_stall[gnt_idx_q] = bus.s_stall;
        end
    end

    // Read data is broadcast; ack/err qualify it per master
    assign bus.m_data_s = {Count{bus.s_data_s}};

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- N-master to 1-slave pipelined Wishbone (B4, with stall) arbiter.
- It is the inverse of the bus multiplexer: several initiators, such as the CPU instruction port, CPU data port and DMA, share one slave port. That port typically feeds the bus multiplexer.
- Ownership is granted per bus cycle (whole m_cyc assertion) with round-robin fairness.
- A registered grant keeps the slave-side timing path short.

Parameters:
- Count, 2, number of masters; must be >= 2.
- DataWidth, 32, data bus width.
- AddrWidth, 32, address bus width.
- SelWidth, DataWidth/8, byte-select width (localparam).
- IdxWidth, $clog2(Count), grant index width (localparam).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- m_data_m  in  [DataWidth-1:0] x Count  master write data.
- m_addr  in  [AddrWidth-1:0] x Count  master address.
- m_sel  in  [SelWidth-1:0] x Count  master byte selects.
- m_cyc, m_stb, m_we  in  1 x Count  master cycle, strobe, write enable.
- m_data_s  out  [DataWidth-1:0] x Count  read data to masters.
- m_ack, m_err, m_stall  out  1 x Count  per-master response and stall.
- s_data_m  out  [DataWidth-1:0]  write data to slave.
- s_addr  out  [AddrWidth-1:0]  address to slave.
- s_sel  out  [SelWidth-1:0]  byte selects to slave.
- s_cyc, s_stb, s_we  out  1  cycle, strobe, write enable to slave.
- s_data_s  in  [DataWidth-1:0]  slave read data.
- s_ack, s_err, s_stall  in  1  slave response and stall.

Behaviour:
- State: gnt_valid (1b), gnt_idx (IdxWidth), last_idx (IdxWidth).
- Reset (async, while reset_n=0): gnt_valid=0, gnt_idx=0, last_idx=Count-1, so master 0 has first priority. Outputs in reset: s_cyc=0, s_stb=0, all m_ack=0, all m_err=0, all m_stall=1.
- IDLE (gnt_valid=0):
  - Slave sees s_cyc=s_stb=0.
  - Winner = first i with m_cyc[i]=1, scanning (last_idx+1) mod Count upward with wrap.
  - If any requester exists, next edge sets gnt_valid=1, gnt_idx=winner, last_idx=winner.
  - Arbitration latency is 1 cycle: the master's cyc/stb reach the slave the cycle after m_cyc first rises.
- GRANTED (gnt_valid=1), g=gnt_idx:
  - s_cyc=m_cyc[g], s_stb=m_stb[g].
  - s_addr, s_data_m, s_sel, s_we come from master g (combinational mux).
  - m_ack[g]=s_ack, m_err[g]=s_err, m_stall[g]=s_stall.
- Non-granted masters, at all times: m_ack=0, m_err=0, m_stall=1.
- m_data_s[i]=s_data_s for every i. Data is broadcast; only ack/err qualify it.
- Release: when m_cyc[g]=0 in GRANTED, next edge clears gnt_valid.
  - There is always exactly one IDLE cycle between owners. No back-to-back handoff.
  - A master that drops and re-raises cyc immediately goes to the back of the rotation.
- Grant is held for the whole m_cyc assertion regardless of other requests. There is no preemption and no timeout.
- Outstanding acks are the master's responsibility: a master holds cyc until all acks or an err arrive.
- Simultaneous events:
  - Ack and release in the same cycle: the ack is delivered, then release occurs.
  - Several masters rising in the same cycle: round-robin order decides.
  - A master's stb asserted during IDLE sees stall=1, so no request is lost.
- Reset mid-cycle forces IDLE immediately. The slave sees s_cyc drop asynchronously; any in-flight slave transaction is abandoned.
- Requirements on gnt_idx:
  - gnt_idx never holds a value >= Count.
  - Whenever the slave sees s_cyc=0, gnt_valid=0 or m_cyc[gnt_idx]=0.

Decomposition:
- Shared wishbone package holds the bus width defaults; no new typedefs.
- One sub-module, wb_rr_picker: combinational round-robin selector.
  - Inputs: req[Count], last_idx.
  - Outputs: any, idx.
  - Reusable by future arbiters (e.g. interrupt priority).
- The state register and steering muxes live in wb_arbiter.

Test Plan:
1. Count=2, only m_cyc[1] and m_stb[1] rise at cycle 0 with addr 0x100 -> cycle 1: s_cyc=1, s_addr=0x100, m_stall[1]=s_stall; cycle 0: m_stall[1]=1.
2. Both masters raise cyc at cycle 0 after reset -> master 0 granted at cycle 1. When master 0 drops cyc, there is 1 IDLE cycle, then master 1 is granted. Master 1 never sees ack during master 0's grant.
3. Both masters request continuously, each holding cyc for 3 cycles, over 20 cycles -> grants alternate 0,1,0,1. No master is granted twice in a row while the other requests.
4. Master 0 owns the bus with a 4-beat pipelined read; slave stalls beat 2 for 2 cycles, and s_err is asserted on beat 4 -> m_ack[0] pulses 3 times, m_err[0] pulses once, m_stall[0] mirrors s_stall. Master 1's ack and err stay 0 throughout.
5. reset_n=0 asserted mid-cycle while master 1 is granted -> s_cyc=0 immediately, without waiting for a clock edge. After release with both masters requesting, master 0 wins.
6. Count=3, last_idx=2, requests from masters 1 and 2 -> master 1 granted. After it releases, with 0 and 2 requesting -> master 2 granted (wrap order).
